// File: rtl/exec_mem_stage_if.sv
// Bundle between the fetch/decode front end and the execute/memory stage.
// The front end drives operands and decoded control. The stage returns the
// write-back value, the next PC and the stall handshake.
interface exec_mem_stage_if;
  logic [15:0] PC;
  logic [15:0] PC_plus1;
  logic [15:0] branch_addr;
  logic [15:0] INSTR;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [15:0] sign_ext_out;
  logic [2:0]  ALUop;
  logic        ALUsrc;
  logic        Jump;
  logic        Branch;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic [15:0] C;
  logic [15:0] PC_next;
  logic        stall;
  logic        wb_valid;
  logic        zero;

  modport master (
    output PC, PC_plus1, branch_addr, INSTR, data1, data2, sign_ext_out,
           ALUop, ALUsrc, Jump, Branch, MemRead, MemWrite, MemToReg,
    input  C, PC_next, stall, wb_valid, zero
  );

  modport slave (
    input  PC, PC_plus1, branch_addr, INSTR, data1, data2, sign_ext_out,
           ALUop, ALUsrc, Jump, Branch, MemRead, MemWrite, MemToReg,
    output C, PC_next, stall, wb_valid, zero
  );
endinterface

// File: rtl/exec_mem_stage.sv
// Execute / memory / write-back stage of the single-cycle MCU.
// Contains the ALU, next-PC selection and a data memory with a fixed
// three-cycle access. A small FSM holds the front end while a load or
// store is in flight.
module exec_mem_stage #(
  parameter int DMEM_DEPTH = 256
) (
  input logic             clk,
  input logic             nClear,
  exec_mem_stage_if.slave bus
);
  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic [15:0]   rdata;
  logic          rd_q;
  logic          wr_q;

  logic [15:0]   op_b;
  logic [15:0]   alu_out;
  logic [15:0]   pc_sel;
  logic          mem_op;

  logic [15:0]   mem [DMEM_DEPTH];

  // ALU: 16-bit result, carries and overflow dropped
  always_comb begin
    op_b    = bus.ALUsrc ? bus.sign_ext_out : bus.data2;
    alu_out = '0;
    unique case (bus.ALUop)
      3'd0: alu_out = bus.data1 + op_b;
      3'd1: alu_out = bus.data1 - op_b;
      3'd2: alu_out = bus.data1 & op_b;
      3'd3: alu_out = bus.data1 | op_b;
      3'd4: alu_out = bus.data1 ^ op_b;
      3'd5: alu_out = bus.data1 << op_b[3:0];
      3'd6: alu_out = bus.data1 >> op_b[3:0];
      3'd7: alu_out = ($signed(bus.data1) < $signed(op_b)) ? 16'h0001 : 16'h0000;
      default: alu_out = '0;
    endcase
  end

  // Next-PC priority and stage outputs.
  // The stall signal comes combinationally from the state, so a memory
  // instruction holds the PC in the same cycle that it is decoded.
  always_comb begin
    mem_op = bus.MemRead | bus.MemWrite;
    bus.zero = (alu_out == 16'h0000);
    if (bus.Jump)
      pc_sel = {bus.PC_plus1[15:12], bus.INSTR[11:0]};
    else if (bus.Branch && bus.zero)
      pc_sel = bus.branch_addr;
    else
      pc_sel = bus.PC_plus1;
    bus.stall    = ((state == IDLE) && mem_op) || (state == ACC);
    bus.wb_valid = ~bus.stall;
    bus.PC_next  = bus.stall ? bus.PC : pc_sel;
    bus.C        = ((state == RESP) && bus.MemToReg) ? rdata : alu_out;
  end

  // Access FSM. The address and data are latched on entry to ACC, so
  // register-file updates during the stall cannot disturb the access.
  always_ff @(posedge clk) begin
    if (!nClear) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: if (mem_op) begin
          addr_q  <= alu_out[AW-1:0];
          wdata_q <= bus.data2;
          wr_q    <= bus.MemWrite;
          rd_q    <= bus.MemRead & ~bus.MemWrite;  // a write wins over a read
          state   <= ACC;
        end
        ACC: begin
          if (rd_q) rdata <= mem[addr_q];
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory array commit. It has no reset, and a reset during ACC
  // suppresses the pending write.
  always_ff @(posedge clk) begin
    if (nClear && (state == ACC) && wr_q)
      mem[addr_q] <= wdata_q;
  end
endmodule

// File: tb/tb_exec_mem_stage.sv
// Directed bench for exec_mem_stage. Inputs change 1ns after the rising
// edge, and outputs are sampled on the falling edge.
module tb_exec_mem_stage;
  logic clk;
  logic nClear;
  int   total;
  int   bad;

  exec_mem_stage_if bus();

  exec_mem_stage #(.DMEM_DEPTH(256)) dut (
    .clk    (clk),
    .nClear (nClear),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic        src, jmp, br;
    logic [15:0] d1, d2, sx, instr, pcp1, ba;
    logic [15:0] c, pcn;
    logic        z;
  } vec_t;

  vec_t v[14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_ctl();
    bus.ALUop = 3'd0; bus.ALUsrc = 1'b0; bus.Jump = 1'b0; bus.Branch = 1'b0;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.MemToReg = 1'b0;
    bus.data1 = '0; bus.data2 = '0; bus.sign_ext_out = '0; bus.INSTR = '0;
    bus.PC = 16'h0100; bus.PC_plus1 = 16'h0101; bus.branch_addr = 16'h0300;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Put a load or store with address = data1 + 0 on the bus.
  task automatic set_mem(input logic rd, input logic wr, input logic m2r,
                         input logic [15:0] addr, input logic [15:0] wdata, input logic jmp);
    clear_ctl();
    bus.ALUsrc = 1'b1; bus.data1 = addr; bus.data2 = wdata;
    bus.MemRead = rd; bus.MemWrite = wr; bus.MemToReg = m2r;
    bus.Jump = jmp; bus.INSTR = 16'h0ABC;
  endtask

  // Run a full three-cycle memory instruction and check each cycle.
  task automatic mem_op(input string name, input logic rd, input logic wr, input logic m2r,
                        input logic [15:0] addr, input logic [15:0] wdata, input logic jmp,
                        input logic [15:0] exp_c, input logic [15:0] exp_pcn);
    set_mem(rd, wr, m2r, addr, wdata, jmp);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({name, "_stall"}, 16'(bus.stall), (k < 2) ? 16'd1 : 16'd0);
      chk({name, "_wbv"}, 16'(bus.wb_valid), (k < 2) ? 16'd0 : 16'd1);
      if (k < 2) chk({name, "_pc_hold"}, bus.PC_next, 16'h0100);
      else begin
        chk({name, "_c"}, bus.C, exp_c);
        chk({name, "_pcn"}, bus.PC_next, exp_pcn);
      end
      next_cyc();
    end
    clear_ctl();
  endtask

  initial begin
    int adv;
    total = 0; bad = 0;
    clear_ctl();
    nClear = 1'b0;

    v[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h8001, 16'h0201, 1'b0};
    v[1]  = '{3'd1, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h7FFF, 16'h0201, 1'b0};
    v[2]  = '{3'd2, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h0000, 16'h0201, 1'b1};
    v[3]  = '{3'd3, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h8001, 16'h0201, 1'b0};
    v[4]  = '{3'd4, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h8001, 16'h0201, 1'b0};
    v[5]  = '{3'd5, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h0000, 16'h0201, 1'b1};
    v[6]  = '{3'd6, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h4000, 16'h0201, 1'b0};
    v[7]  = '{3'd7, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h0001, 16'h0201, 1'b0};
    v[8]  = '{3'd0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0005, 16'hFFFF, 16'h0000, 16'h0201, 16'h0300, 16'h000F, 16'h0201, 1'b0};
    v[9]  = '{3'd7, 1'b0, 1'b0, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h0000, 16'h0201, 1'b1};
    v[10] = '{3'd1, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0201, 16'h0040, 16'h0000, 16'h0040, 1'b1};
    v[11] = '{3'd1, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 16'h0201, 16'h0040, 16'hFFFF, 16'h0201, 1'b0};
    v[12] = '{3'd1, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0123, 16'h5000, 16'h0040, 16'h0000, 16'h5123, 1'b1};
    v[13] = '{3'd5, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0013, 16'h0000, 16'h0000, 16'h0201, 16'h0300, 16'h0008, 16'h0201, 1'b0};

    // Reset for two edges, then check the idle outputs.
    repeat (2) @(posedge clk);
    #1 nClear = 1'b1;
    @(negedge clk);
    chk("rst_stall", 16'(bus.stall), 16'd0);
    chk("rst_wbv", 16'(bus.wb_valid), 16'd1);
    next_cyc();
    bus.data1 = 16'd3; bus.data2 = 16'd4;
    @(negedge clk);
    chk("rst_add_c", bus.C, 16'd7);
    chk("rst_add_pcn", bus.PC_next, 16'h0101);
    next_cyc();

    // Single-cycle vectors: ALU sweep, branch and jump.
    for (int i = 0; i < 14; i++) begin
      clear_ctl();
      bus.PC = 16'h0200;
      bus.ALUop = v[i].op; bus.ALUsrc = v[i].src; bus.Jump = v[i].jmp; bus.Branch = v[i].br;
      bus.data1 = v[i].d1; bus.data2 = v[i].d2; bus.sign_ext_out = v[i].sx;
      bus.INSTR = v[i].instr; bus.PC_plus1 = v[i].pcp1; bus.branch_addr = v[i].ba;
      @(negedge clk);
      chk($sformatf("vec%0d_c", i), bus.C, v[i].c);
      chk($sformatf("vec%0d_pcn", i), bus.PC_next, v[i].pcn);
      chk($sformatf("vec%0d_zero", i), 16'(bus.zero), 16'(v[i].z));
      chk($sformatf("vec%0d_stall", i), 16'(bus.stall), 16'd0);
      next_cyc();
    end
    clear_ctl();

    // Read and write both set: treated as a write, and rdata keeps its reset value of 0.
    mem_op("rdwr", 1'b1, 1'b1, 1'b1, 16'h00FE, 16'h7777, 1'b0, 16'h0000, 16'h0101);
    mem_op("sw_beef", 1'b0, 1'b1, 1'b0, 16'h0012, 16'hBEEF, 1'b0, 16'h0012, 16'h0101);
    mem_op("lw_beef", 1'b1, 1'b0, 1'b1, 16'h0012, 16'h0000, 1'b0, 16'hBEEF, 16'h0101);
    // A jump together with a load redirects the PC only in RESP.
    mem_op("lw_jmp", 1'b1, 1'b0, 1'b1, 16'h00FE, 16'h0000, 1'b1, 16'h7777, 16'h0ABC);
    mem_op("sw_20", 1'b0, 1'b1, 1'b0, 16'h0020, 16'h1111, 1'b0, 16'h0020, 16'h0101);

    // A store aborted by reset while in ACC.
    set_mem(1'b0, 1'b1, 1'b0, 16'h0020, 16'h2222, 1'b0);
    @(negedge clk);
    chk("abort_stall0", 16'(bus.stall), 16'd1);
    next_cyc();
    nClear = 1'b0;
    next_cyc();
    nClear = 1'b1;
    clear_ctl();
    @(negedge clk);
    chk("abort_idle_stall", 16'(bus.stall), 16'd0);
    next_cyc();
    mem_op("lw_20", 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'h1111, 16'h0101);

    // Back-to-back loads.
    mem_op("sw_30", 1'b0, 1'b1, 1'b0, 16'h0030, 16'hA5A5, 1'b0, 16'h0030, 16'h0101);
    mem_op("sw_31", 1'b0, 1'b1, 1'b0, 16'h0031, 16'h5A5A, 1'b0, 16'h0031, 16'h0101);
    adv = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc == 0) set_mem(1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0);
      if (cyc == 3) set_mem(1'b1, 1'b0, 1'b1, 16'h0031, 16'h0000, 1'b0);
      @(negedge clk);
      chk($sformatf("b2b%0d_stall", cyc), 16'(bus.stall), (cyc % 3 == 2) ? 16'd0 : 16'd1);
      if (!bus.stall) begin
        adv++;
        chk($sformatf("b2b%0d_pcn", cyc), bus.PC_next, 16'h0101);
      end
      if (cyc == 2) chk("b2b_c0", bus.C, 16'hA5A5);
      if (cyc == 5) chk("b2b_c1", bus.C, 16'h5A5A);
      next_cyc();
    end
    chk("b2b_advances", 16'(adv), 16'd2);
    clear_ctl();
    @(negedge clk);
    chk("b2b_idle", 16'(bus.stall), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_mem_stage.md
# exec_mem_stage

Execute/memory/write-back stage of the single-cycle MCU: consumes the register operands, decoded control, sign-extended immediate and branch target produced by the fetch/decode datapath, and returns the write-back value `C` and the next program counter `PC_next`. Contains the ALU, a 256x16 data memory with a fixed multi-cycle access, and a small FSM that stalls the front end during loads and stores.

## Interface
- `DMEM_DEPTH`, 256: data-memory words; address is `alu_out[7:0]`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `nClear`  in  1  reset, synchronous, active-low.
- `PC`  in  16  current program counter.
- `PC_plus1`  in  16  PC + 1 from the front-end adder.
- `branch_addr`  in  16  PC_plus1 + sign-extended INSTR[3:0].
- `INSTR`  in  16  current instruction; INSTR[11:0] is the jump field, INSTR[3:0] the immediate.
- `data1`, `data2`  in  16 each  register-file read ports.
- `sign_ext_out`  in  16  sign-extended immediate.
- `ALUop`  in  3  ALU operation.
- `ALUsrc`  in  1  1: operand B = sign_ext_out; 0: data2.
- `Jump`, `Branch`, `MemRead`, `MemWrite`, `MemToReg`  in  1 each  decoded control.
- `C`  out  16  write-back data to the register file.
- `PC_next`  out  16  value the PC register loads on the next edge.
- `stall`  out  1  1: front end must hold; PC_next = PC.
- `wb_valid`  out  1  = ~stall; register-file write enable must be RegWrite & wb_valid.
- `zero`  out  1  alu_out == 16'h0000.

## Operation
- ALU, operand A = data1, B per ALUsrc; 16-bit result, carries/overflow discarded:
  - 000 ADD, 001 SUB (A−B, two's complement), 010 AND, 011 OR, 100 XOR,
  - 101 SHL A by B[3:0], 110 SHR logical A by B[3:0], 111 SLT signed: 16'h0001 if A<B else 16'h0000.
- PC selection (when stall=0), priority order: Jump → {PC_plus1[15:12], INSTR[11:0]}; Branch & zero → branch_addr; else PC_plus1.
- FSM states IDLE, ACC, RESP; reset state IDLE.
  - IDLE, no mem op: combinational single-cycle instruction, stall=0, C = alu_out.
  - IDLE, MemRead or MemWrite: stall=1; latch addr=alu_out[7:0], wdata=data2, rd/wr flags; → ACC.
  - ACC: stall=1; on the edge leaving ACC, write commits (mem[addr]<=wdata) if wr, read data registered into rdata if rd; → RESP.
  - RESP: stall=0, PC_next selected normally, C = MemToReg ? rdata : alu_out; → IDLE unconditionally (no re-trigger from the same instruction).
- MemRead and MemWrite both 1: treated as write only; rdata keeps its previous value.
- Latched address/data are used in ACC, so register-file changes during the stall cannot corrupt the access.
- Data memory is not cleared by reset; only FSM, latches and rdata are reset.

## Timing
- Reset (nClear=0 at a rising edge): state=IDLE, rdata=0, addr latch=0, wdata latch=0. Outputs after reset are combinational from the IDLE state: stall=0, wb_valid=1.
- Non-memory instruction: 1 cycle, zero stall.
- Load/store: 3 cycles (IDLE-stall, ACC-stall, RESP); the PC advances at the end of RESP.
- Store data is visible to a load issued in the cycle after RESP.
- nClear low during ACC: the write is aborted (no memory update), FSM → IDLE.
- Back-to-back memory instructions: RESP → IDLE, then the new instruction re-enters ACC; no lost or duplicated access.
- Jump/Branch decoded together with MemRead/MemWrite: the PC redirect applies in RESP only.

## Test plan
- Reset: hold nClear=0 for 2 cycles → state IDLE, stall=0, rdata=0; ADD data1=3, data2=4, ALUsrc=0 → C=7, PC_next=PC_plus1.
- ALU sweep: A=16'h8000, B=16'h0001, all 8 ops → 8001, 7FFF, 0000, 8001, 8001, 0000, 4000, 0001 (SLT signed true).
- Store/load: SW data2=16'hBEEF to addr 16'h0012, then LW from the same address → stall=1,1,0 for each; C=16'hBEEF in RESP of the LW; wb_valid=0 during stalls.
- Branch: SUB 5−5 with Branch=1, branch_addr=16'h0040 → zero=1, PC_next=0040; 5−6 → PC_next=PC_plus1. Jump with INSTR[11:0]=12'h123, PC_plus1=16'h5000 → PC_next=16'h5123.
- Reset in ACC of a store to 16'h0020 → memory word unchanged (a later load returns the prior value), FSM IDLE.
- Back-to-back LW, LW → exactly 6 cycles, two distinct correct C values; PC advances exactly twice.
